// File: rtl/opb_register_simulink2ppc.sv
// OPB slave that publishes a fabric word to the PPC with new-flag/overflow status.
// Optional overflow counter: define OPB_REGISTER_SIMULINK2PPC_OVF_CNT_EN.
module opb_register_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h01000600,
  parameter logic [31:0] C_HIGHADDR   = 32'h010006FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  output logic        Sl_xferAck,
  input  logic [31:0] user_data_in,
  input  logic        user_valid,
  output logic        user_new
);

  localparam int unsigned FAMILY_LEN = $bits(C_FAMILY);
  localparam bit CFG_OK = (C_OPB_AWIDTH == 32) && (C_OPB_DWIDTH == 32) && (FAMILY_LEN > 0);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;
  typedef enum logic [1:0] {R_DATA, R_STATUS, R_CTRL, R_RSVD} reg_t;

  state_t      state;
  reg_t        reg_sel;
  logic        rnw_q;
  logic        clr_req;
  logic        xfer_ack;
  logic        new_flag;
  logic [31:0] capture;
  logic        hit;
  logic        data_rd;
  logic [0:31] rd_val;

  assign hit = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR)
               && (state == S_IDLE);

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state    <= S_IDLE;
      reg_sel  <= R_DATA;
      rnw_q    <= 1'b0;
      clr_req  <= 1'b0;
      xfer_ack <= 1'b0;
    end else begin
      xfer_ack <= 1'b0;
      unique case (state)
        S_IDLE: if (hit) begin
          state    <= S_ACK;
          xfer_ack <= 1'b1;
          reg_sel  <= reg_t'(OPB_ABus[28:29]);
          rnw_q    <= OPB_RNW;
          clr_req  <= OPB_BE[3] & OPB_DBus[31];
        end
        S_ACK:  state <= S_HOLD;
        S_HOLD: if (!OPB_select) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // A DATA read consumes the word at the end of ACK; a same-cycle capture wins.
  assign data_rd = (state == S_ACK) && rnw_q && (reg_sel == R_DATA);

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      capture  <= '0;
      new_flag <= 1'b0;
    end else if (user_valid) begin
      capture  <= user_data_in;
      new_flag <= 1'b1;
    end else if (data_rd) begin
      new_flag <= 1'b0;
    end
  end

`ifdef OPB_REGISTER_SIMULINK2PPC_OVF_CNT_EN
  logic [15:0] ovf_cnt;
  logic        ovf;
  logic        ctrl_clr;

  assign ovf      = user_valid && new_flag;
  assign ctrl_clr = (state == S_ACK) && !rnw_q && (reg_sel == R_CTRL) && clr_req;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ovf_cnt <= '0;
    end else if (ctrl_clr) begin
      ovf_cnt <= {15'd0, ovf};
    end else if (ovf && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`endif

  // Read data is decoded from registered state so it drops to zero with reset.
  always_comb begin
    rd_val = '0;
    if ((state == S_ACK) && rnw_q) begin
      unique case (reg_sel)
        R_DATA: rd_val = capture;
        R_STATUS: begin
`ifdef OPB_REGISTER_SIMULINK2PPC_OVF_CNT_EN
          rd_val[0:15] = ovf_cnt;
`endif
          rd_val[31] = new_flag;
        end
        default: rd_val = '0;
      endcase
    end
  end

  assign Sl_DBus    = rd_val;
  assign Sl_xferAck = xfer_ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign user_new   = new_flag;

  logic unused_ok;
`ifdef OPB_REGISTER_SIMULINK2PPC_OVF_CNT_EN
  assign unused_ok = &{1'b0, OPB_seqAddr, OPB_BE, OPB_DBus, CFG_OK};
`else
  assign unused_ok = &{1'b0, OPB_seqAddr, OPB_BE, OPB_DBus, CFG_OK, clr_req};
`endif

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Randomised self-checking bench for opb_register_simulink2ppc against a register-level model.
// Follows OPB_REGISTER_SIMULINK2PPC_OVF_CNT_EN to decide whether overflow counting is expected.
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] BASE = 32'h01000600;
  localparam logic [31:0] HIGH = 32'h010006FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:31] OPB_ABus = '0;
  logic [0:3]  OPB_BE = '0;
  logic [0:31] OPB_DBus = '0;
  logic        OPB_RNW = 1'b0;
  logic        OPB_select = 1'b0;
  logic        OPB_seqAddr = 1'b0;
  logic [0:31] Sl_DBus;
  logic        Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck;
  logic [31:0] user_data_in = '0;
  logic        user_valid = 1'b0;
  logic        user_new;

  always #5 clk = ~clk;

  opb_register_simulink2ppc #(
    .C_BASEADDR  (BASE),
    .C_HIGHADDR  (HIGH),
    .C_OPB_AWIDTH(32),
    .C_OPB_DWIDTH(32),
    .C_FAMILY    ("virtex5")
  ) dut (
    .OPB_Clk     (clk),
    .OPB_Rst_n   (rst_n),
    .OPB_ABus    (OPB_ABus),
    .OPB_BE      (OPB_BE),
    .OPB_DBus    (OPB_DBus),
    .OPB_RNW     (OPB_RNW),
    .OPB_select  (OPB_select),
    .OPB_seqAddr (OPB_seqAddr),
    .Sl_DBus     (Sl_DBus),
    .Sl_errAck   (Sl_errAck),
    .Sl_retry    (Sl_retry),
    .Sl_toutSup  (Sl_toutSup),
    .Sl_xferAck  (Sl_xferAck),
    .user_data_in(user_data_in),
    .user_valid  (user_valid),
    .user_new    (user_new)
  );

  // Model of the visible register file
  logic [31:0] m_cap = '0;
  logic        m_new = 1'b0;
  logic [15:0] m_cnt = '0;
  int          n_checks = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_word();
    return {m_cnt, 15'd0, m_new};
  endfunction

  task automatic model_reset();
    m_cap = '0;
    m_new = 1'b0;
    m_cnt = '0;
  endtask

  task automatic model_valid(input logic [31:0] d, input logic clr);
    logic ovf;
    ovf   = m_new;
    m_cap = d;
    m_new = 1'b1;
`ifdef OPB_REGISTER_SIMULINK2PPC_OVF_CNT_EN
    if (clr) m_cnt = ovf ? 16'd1 : 16'd0;
    else if (ovf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`else
    if (clr && ovf) m_cnt = '0;
`endif
  endtask

  task automatic pulse(input logic [31:0] d);
    user_valid   = 1'b1;
    user_data_in = d;
    @(posedge clk); #1;
    user_valid = 1'b0;
    model_valid(d, 1'b0);
    check("pulse_user_new", 32'(user_new), 32'(m_new));
  endtask

  // One full transfer: hit, ACK, HOLD, back to IDLE; optional capture in the ACK cycle.
  task automatic opb_access(input logic [31:0] addr, input logic rnw, input logic [0:3] be,
                            input logic [0:31] wdata, input logic vin, input logic [31:0] vdata,
                            input string tag);
    logic [31:0] exp;
    int unsigned r;
    logic        clr;
    r   = (addr >> 2) & 32'd3;
    exp = '0;
    if (rnw && r == 0) exp = m_cap;
    if (rnw && r == 1) exp = status_word();
    clr = !rnw && (r == 2) && be[3] && wdata[31];
    OPB_ABus = addr; OPB_RNW = rnw; OPB_BE = be; OPB_DBus = wdata; OPB_select = 1'b1;
    @(posedge clk); #1;
    check({tag, "_ack"}, 32'(Sl_xferAck), 32'd1);
    check({tag, "_rdata"}, Sl_DBus, exp);
    check({tag, "_new_in_ack"}, 32'(user_new), 32'(m_new));
    if (vin) begin
      user_valid = 1'b1;
      user_data_in = vdata;
    end
    @(posedge clk); #1;
    user_valid = 1'b0;
    if (vin) model_valid(vdata, clr);
    else begin
      if (rnw && r == 0) m_new = 1'b0;
      if (clr) m_cnt = '0;
    end
    check({tag, "_ack_one_cycle"}, 32'(Sl_xferAck), 32'd0);
    check({tag, "_dbus_hold"}, Sl_DBus, 32'd0);
    check({tag, "_new_after"}, 32'(user_new), 32'(m_new));
    OPB_select = 1'b0;
    OPB_DBus = $urandom;
    @(posedge clk); #1;
  endtask

  task automatic miss(input logic [31:0] addr, input int unsigned cycles, input string tag);
    OPB_ABus = addr; OPB_RNW = 1'b1; OPB_BE = 4'hF; OPB_select = 1'b1;
    for (int unsigned i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check({tag, "_no_ack"}, 32'(Sl_xferAck), 32'd0);
      check({tag, "_no_data"}, Sl_DBus, 32'd0);
    end
    OPB_select = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    check("reset_ack", 32'(Sl_xferAck), 32'd0);
    check("reset_dbus", Sl_DBus, 32'd0);
    check("reset_user_new", 32'(user_new), 32'd0);
    check("tied_outputs", {29'd0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Publish and read back a word
    pulse(32'hDEADBEEF);
    opb_access(BASE + 32'h0, 1'b1, 4'h0, '0, 1'b0, '0, "data_rd_deadbeef");
    check("deadbeef_consumed", 32'(user_new), 32'd0);

    // Capture coinciding with the DATA-read ACK
    pulse(32'h1);
    opb_access(BASE + 32'h0, 1'b1, 4'hF, '0, 1'b1, 32'h2, "data_rd_race");
    check("race_new_stays", 32'(user_new), 32'd1);
    opb_access(BASE + 32'h0, 1'b1, 4'hF, '0, 1'b0, '0, "data_rd_after_race");

    // Three captures without a read
    opb_access(BASE + 32'h8, 1'b0, 4'hF, 32'h1, 1'b0, '0, "ctrl_clear0");
    pulse(32'h11); pulse(32'h22); pulse(32'h33);
`ifdef OPB_REGISTER_SIMULINK2PPC_OVF_CNT_EN
    check("model_status_three", status_word(), 32'h00020001);
`endif
    opb_access(BASE + 32'h4, 1'b1, 4'h0, '0, 1'b0, '0, "status_three");

    // Saturation then clear
    pulse(32'hA5A50000);
    user_valid = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      user_data_in = 32'(i);
      @(posedge clk); #1;
    end
    user_valid = 1'b0;
    m_cap = 32'd65539;
    m_new = 1'b1;
`ifdef OPB_REGISTER_SIMULINK2PPC_OVF_CNT_EN
    begin
      int unsigned tot;
      tot = 32'(m_cnt) + 32'd65540;
      m_cnt = (tot > 32'd65535) ? 16'hFFFF : tot[15:0];
    end
`endif
    opb_access(BASE + 32'h4, 1'b1, 4'h0, '0, 1'b0, '0, "status_saturated");
    opb_access(BASE + 32'h8, 1'b0, 4'hE, 32'h1, 1'b0, '0, "ctrl_be3_low");
    opb_access(BASE + 32'h4, 1'b1, 4'h0, '0, 1'b0, '0, "status_not_cleared");
    opb_access(BASE + 32'h8, 1'b0, 4'hF, 32'h1, 1'b0, '0, "ctrl_clear");
    opb_access(BASE + 32'h4, 1'b1, 4'h0, '0, 1'b0, '0, "status_cleared");
    opb_access(BASE + 32'h8, 1'b0, 4'hF, 32'h1, 1'b1, 32'h77, "ctrl_clear_with_ovf");
    opb_access(BASE + 32'h4, 1'b1, 4'h0, '0, 1'b0, '0, "status_clear_ovf");
    opb_access(BASE + 32'h8, 1'b1, 4'hF, '0, 1'b0, '0, "ctrl_read_zero");
    opb_access(HIGH, 1'b1, 4'hF, '0, 1'b0, '0, "rsvd_read_high");

    // Out of range
    miss(BASE - 32'd1, 8, "below_base");
    miss(HIGH + 32'd1, 8, "above_high");

    // Reset during ACK
    pulse(32'hCAFE0001); pulse(32'hCAFE0002);
    OPB_ABus = BASE + 32'h4; OPB_RNW = 1'b1; OPB_select = 1'b1;
    @(posedge clk); #1;
    check("rst_ack_pre", 32'(Sl_xferAck), 32'd1);
    rst_n = 1'b0; #1;
    model_reset();
    check("rst_ack_kill", 32'(Sl_xferAck), 32'd0);
    check("rst_dbus_kill", Sl_DBus, 32'd0);
    check("rst_new_kill", 32'(user_new), 32'd0);
    OPB_select = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    opb_access(BASE + 32'h4, 1'b1, 4'h0, '0, 1'b0, '0, "status_after_rst");

    // Reset during HOLD with select held: fresh hit after release
    pulse(32'hBEEF0000);
    OPB_ABus = BASE + 32'h4; OPB_RNW = 1'b1; OPB_select = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold_no_ack", 32'(Sl_xferAck), 32'd0);
    rst_n = 1'b0; #1;
    model_reset();
    check("rst_hold_ack", 32'(Sl_xferAck), 32'd0);
    check("rst_hold_dbus", Sl_DBus, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("fresh_hit_ack", 32'(Sl_xferAck), 32'd1);
    check("fresh_hit_dbus", Sl_DBus, status_word());
    OPB_select = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      int unsigned op;
      op = $urandom_range(0, 7);
      if (op < 2) begin
        pulse($urandom);
      end else if (op < 7) begin
        logic [31:0] a;
        logic [0:31] wd;
        a  = BASE + $urandom_range(0, 255);
        wd = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom;
        opb_access(a, 1'($urandom), 4'($urandom), wd, ($urandom_range(0, 3) == 0),
                   $urandom, "rand_access");
      end else begin
        logic [31:0] a;
        a = $urandom_range(0, 1) ? (BASE - 32'd1 - $urandom_range(0, 4096))
                                 : (HIGH + 32'd1 + $urandom_range(0, 4096));
        miss(a, 2, "rand_miss");
      end
    end
    opb_access(BASE + 32'h4, 1'b1, 4'h0, '0, 1'b0, '0, "final_status");
    opb_access(BASE + 32'h0, 1'b1, 4'h0, '0, 1'b0, '0, "final_data");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
